// File: rtl/tx_arb_pkg.sv
// Shared definitions for the rotating-token transmitter arbiter:
// default flit width, requester limit and the FSM state encoding.
package tx_arb_pkg;

  localparam int FLIT_W    = 55;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tx_token_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request found
// when searching token, token+1, ... modulo N_REQ.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TOKW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TOKW-1:0]  token,
  output logic [TOKW-1:0]  grant,
  output logic             any
);

  logic [TOKW:0] idx_s;

  // Priority search; the index wraps by explicit compare so non-power-of-two N_REQ works.
  always_comb begin
    grant = {TOKW{1'b0}};
    any   = 1'b0;
    idx_s = {(TOKW+1){1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, token} + (TOKW+1)'(k);
      if (idx_s >= (TOKW+1)'(N_REQ)) begin
        idx_s = idx_s - (TOKW+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!any && req[idx_s[TOKW-1:0]]) begin
        grant = idx_s[TOKW-1:0];
        any   = 1'b1;
      end else begin
        grant = grant;
        any   = any;
      end
    end
  end

endmodule

// File: rtl/tx_token_arbiter.sv
// Rotating-token arbiter sharing one serial transmitter between N_REQ requesters;
// a new grant is issued only after the previous serial frame has completed.
module tx_token_arbiter #(
  parameter int N_REQ       = 4,
  parameter int FLIT_W      = tx_arb_pkg::FLIT_W,
  parameter int ACC_TIMEOUT = 15
) (
  input  logic                      Clk_S,
  input  logic                      Rst,
  input  logic [N_REQ-1:0]          Req_Valid,
  input  logic [N_REQ*FLIT_W-1:0]   Req_Data,
  output logic [N_REQ-1:0]          Req_Ack,
  output logic [FLIT_W-1:0]         TX_Data,
  output logic                      TX_Data_Valid,
  input  logic                      TX_Ready,
  output logic [$clog2(N_REQ)-1:0]  Token,
  output logic                      Busy,
  output logic                      Abort
);

  import tx_arb_pkg::*;

  localparam int TOKW  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACC_TIMEOUT + 1);

  arb_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [TOKW-1:0]   token_r, token_nxt_s, grant_s;
  logic              any_s, timeout_s;
  logic [N_REQ-1:0]  ack_r, ack_nxt_s;
  logic [FLIT_W-1:0] data_r, data_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              busy_r, abort_r, abort_nxt_s;
  logic [FLIT_W-1:0] flit_s [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_flit
    assign flit_s[i] = Req_Data[i*FLIT_W +: FLIT_W];
  end

  rr_pick #(.N_REQ(N_REQ), .TOKW(TOKW)) u_pick (
    .req   (Req_Valid),
    .token (token_r),
    .grant (grant_s),
    .any   (any_s)
  );

  // Counter was cleared on SEND entry, so this edge is the ACC_TIMEOUT-th one in SEND.
  assign timeout_s = (cnt_r == CNT_W'(ACC_TIMEOUT - 1));

  // State register.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_nxt_s = SEND;
        else       state_nxt_s = IDLE;
      end
      SEND: begin
        if (!TX_Ready)      state_nxt_s = WAIT_DONE;
        else if (timeout_s) state_nxt_s = IDLE;
        else                state_nxt_s = SEND;
      end
      WAIT_DONE: begin
        if (TX_Ready) state_nxt_s = IDLE;
        else          state_nxt_s = WAIT_DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, capture register and timeout counter.
  always_comb begin
    token_nxt_s = token_r;
    ack_nxt_s   = {N_REQ{1'b0}};
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    abort_nxt_s = 1'b0;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          data_nxt_s         = flit_s[grant_s];
          ack_nxt_s[grant_s] = 1'b1;
          valid_nxt_s        = 1'b1;
          cnt_nxt_s          = {CNT_W{1'b0}};
          if (grant_s == TOKW'(N_REQ - 1)) token_nxt_s = {TOKW{1'b0}};
          else                             token_nxt_s = grant_s + TOKW'(1);
        end else begin
          data_nxt_s = data_r;
        end
      end
      SEND: begin
        if (!TX_Ready) begin
          valid_nxt_s = 1'b0;
        end else if (timeout_s) begin
          valid_nxt_s = 1'b0;
          abort_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        valid_nxt_s = 1'b0;
      end
      default: begin
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      token_r <= {TOKW{1'b0}};
      ack_r   <= {N_REQ{1'b0}};
      data_r  <= {FLIT_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      abort_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      token_r <= token_nxt_s;
      ack_r   <= ack_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      abort_r <= abort_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign Token         = token_r;
  assign Req_Ack       = ack_r;
  assign TX_Data       = data_r;
  assign TX_Data_Valid = valid_r;
  assign Busy          = busy_r;
  assign Abort         = abort_r;

endmodule

// File: tb/tb_tx_token_arbiter.sv
// Directed self-checking bench for tx_token_arbiter (N_REQ=4, FLIT_W=55, ACC_TIMEOUT=15).
module tb_tx_token_arbiter;

  localparam int N     = 4;
  localparam int FW    = 55;
  localparam int TMO   = 15;

  logic              clk = 1'b0;
  logic              Rst;
  logic [N-1:0]      Req_Valid;
  logic [N*FW-1:0]   Req_Data;
  logic [N-1:0]      Req_Ack;
  logic [FW-1:0]     TX_Data;
  logic              TX_Data_Valid;
  logic              TX_Ready;
  logic [1:0]        Token;
  logic              Busy;
  logic              Abort;
  logic [FW-1:0]     flit [N];
  int                vectors = 0;
  int                miscompares = 0;

  assign Req_Data = {flit[3], flit[2], flit[1], flit[0]};

  tx_token_arbiter #(.N_REQ(N), .FLIT_W(FW), .ACC_TIMEOUT(TMO)) dut (
    .Clk_S(clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ack(Req_Ack), .TX_Data(TX_Data), .TX_Data_Valid(TX_Data_Valid),
    .TX_Ready(TX_Ready), .Token(Token), .Busy(Busy), .Abort(Abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame();
    TX_Ready = 1'b0; tick();
    TX_Ready = 1'b1; tick();
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req_Valid = 4'h0; TX_Ready = 1'b1; tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req_Valid = 4'hF; TX_Ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({Req_Ack, TX_Data_Valid, Busy, Abort, Token} !== 9'd0 || TX_Data !== 55'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ack=%b v=%b busy=%b abort=%b tok=%0d data=%h expected all zero",
               Req_Ack, TX_Data_Valid, Busy, Abort, Token, TX_Data);
    end
    Rst = 1'b0; tick();
    vectors++;
    if (Req_Ack !== 4'b0001 || Token !== 2'd1 || TX_Data_Valid !== 1'b1 || TX_Data !== flit[0]) begin
      miscompares++;
      $display("FAIL reset_first_grant: got ack=%b tok=%0d v=%b data=%h expected ack=0001 tok=1 v=1 data=%h",
               Req_Ack, Token, TX_Data_Valid, TX_Data, flit[0]);
    end
    Req_Valid = 4'h0;
    finish_frame();
  endtask

  task automatic test_round_robin();
    int acks[N];
    for (int i = 0; i < N; i++) acks[i] = 0;
    do_reset();
    Req_Valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      tick();
      vectors++;
      if (Req_Ack !== (4'b0001 << g) || TX_Data !== flit[g] || Token !== 2'((g + 1) % N)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got ack=%b data=%h tok=%0d expected ack=%b data=%h tok=%0d",
                 k, Req_Ack, TX_Data, Token, 4'b0001 << g, flit[g], (g + 1) % N);
      end
      for (int i = 0; i < N; i++) acks[i] += int'(Req_Ack[i]);
      TX_Ready = 1'b0; tick();
      vectors++;
      if (Req_Ack !== 4'h0 || TX_Data_Valid !== 1'b0 || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_wait[%0d]: got ack=%b v=%b busy=%b expected ack=0000 v=0 busy=1",
                 k, Req_Ack, TX_Data_Valid, Busy);
      end
      TX_Ready = 1'b1; tick();
      vectors++;
      if (Busy !== 1'b0 || Req_Ack !== 4'h0) begin
        miscompares++;
        $display("FAIL rr_idle[%0d]: got busy=%b ack=%b expected busy=0 ack=0000", k, Busy, Req_Ack);
      end
    end
    Req_Valid = 4'h0;
    vectors++;
    if (acks[0] != 2 || acks[1] != 1 || acks[2] != 1 || acks[3] != 1) begin
      miscompares++;
      $display("FAIL rr_ack_count: got %0d,%0d,%0d,%0d expected 2,1,1,1", acks[0], acks[1], acks[2], acks[3]);
    end
  endtask

  task automatic test_token_wrap();
    do_reset();
    Req_Valid = 4'b0100; tick();
    vectors++;
    if (Token !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_setup_token: got %0d expected 3", Token);
    end
    finish_frame();
    Req_Valid = 4'b0101; tick();
    vectors++;
    if (Req_Ack !== 4'b0001 || Token !== 2'd1 || TX_Data !== flit[0]) begin
      miscompares++;
      $display("FAIL wrap_grant0: got ack=%b tok=%0d data=%h expected ack=0001 tok=1 data=%h",
               Req_Ack, Token, TX_Data, flit[0]);
    end
    finish_frame();
    tick();
    vectors++;
    if (Req_Ack !== 4'b0100 || Token !== 2'd3 || TX_Data !== flit[2]) begin
      miscompares++;
      $display("FAIL wrap_grant2: got ack=%b tok=%0d data=%h expected ack=0100 tok=3 data=%h",
               Req_Ack, Token, TX_Data, flit[2]);
    end
    Req_Valid = 4'h0;
    finish_frame();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    Req_Valid = 4'b0010; TX_Ready = 1'b1; tick();
    Req_Valid = 4'h0;
    for (int c = 1; c < TMO; c++) begin
      tick();
      if (TX_Data_Valid !== 1'b1 || Abort !== 1'b0) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0d early drop/abort cycles expected 0", early);
    end
    tick();
    vectors++;
    if (TX_Data_Valid !== 1'b0 || Abort !== 1'b1 || Busy !== 1'b0 || Token !== 2'd2) begin
      miscompares++;
      $display("FAIL timeout_abort: got v=%b abort=%b busy=%b tok=%0d expected v=0 abort=1 busy=0 tok=2",
               TX_Data_Valid, Abort, Busy, Token);
    end
    tick();
    vectors++;
    if (Abort !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got abort=%b busy=%b expected abort=0 busy=0", Abort, Busy);
    end
  endtask

  task automatic test_handshake_hold();
    int bad;
    bad = 0;
    do_reset();
    Req_Valid = 4'b1000; TX_Ready = 1'b1; tick();
    vectors++;
    if (Req_Ack !== 4'b1000 || Token !== 2'd0 || TX_Data !== flit[3]) begin
      miscompares++;
      $display("FAIL hold_grant3: got ack=%b tok=%0d data=%h expected ack=1000 tok=0 data=%h",
               Req_Ack, Token, TX_Data, flit[3]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (TX_Data !== flit[3] || TX_Data_Valid !== 1'b1 || Busy !== 1'b1 || Req_Ack !== 4'h0) bad++;
    end
    TX_Ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (Busy !== 1'b1 || Req_Ack !== 4'h0 || TX_Data_Valid !== 1'b0 || TX_Data !== flit[3]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_stable: got %0d bad cycles expected 0", bad);
    end
    TX_Ready = 1'b1; tick();
    vectors++;
    if (Busy !== 1'b0 || Req_Ack !== 4'h0) begin
      miscompares++;
      $display("FAIL hold_return: got busy=%b ack=%b expected busy=0 ack=0000", Busy, Req_Ack);
    end
    tick();
    vectors++;
    if (Req_Ack !== 4'b1000 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_regrant: got ack=%b busy=%b expected ack=1000 busy=1", Req_Ack, Busy);
    end
    Req_Valid = 4'h0;
    finish_frame();
  endtask

  task automatic test_mid_reset();
    do_reset();
    Req_Valid = 4'b0001; tick();
    TX_Ready = 1'b0; tick();
    vectors++;
    if (Token !== 2'd1 || Busy !== 1'b1 || TX_Data_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_setup: got tok=%0d busy=%b v=%b expected tok=1 busy=1 v=0", Token, Busy, TX_Data_Valid);
    end
    Rst = 1'b1; tick();
    vectors++;
    if (Token !== 2'd0 || Busy !== 1'b0 || Abort !== 1'b0 || Req_Ack !== 4'h0 || TX_Data !== 55'd0) begin
      miscompares++;
      $display("FAIL midrst_state: got tok=%0d busy=%b abort=%b ack=%b data=%h expected all zero",
               Token, Busy, Abort, Req_Ack, TX_Data);
    end
    Rst = 1'b0; TX_Ready = 1'b1; tick();
    vectors++;
    if (Req_Ack !== 4'b0001 || Token !== 2'd1 || Abort !== 1'b0 || TX_Data !== flit[0]) begin
      miscompares++;
      $display("FAIL midrst_regrant: got ack=%b tok=%0d abort=%b data=%h expected ack=0001 tok=1 abort=0 data=%h",
               Req_Ack, Token, Abort, TX_Data, flit[0]);
    end
    Req_Valid = 4'h0;
    finish_frame();
  endtask

  initial begin
    for (int i = 0; i < N; i++) flit[i] = 55'h1 << i;
    Rst = 1'b1; Req_Valid = 4'h0; TX_Ready = 1'b1;
    test_reset();
    test_round_robin();
    test_token_wrap();
    test_timeout();
    test_handshake_hold();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
